fifo_uart_tx: RTL and testbench

//  Drains bytes from the on-chip IO FIFO's read side and serializes each one as a UART frame on serial_out.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/fifo.sv | 64 ++++++
 rtl/uart_baud_counter.sv | 28 ++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-time arithmetic and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      LATCH  = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      STOP   = 3'd5,
      PARITY = 3'd6
   } uart_state_t;

   localparam logic MARK  = 1'b1;
   localparam logic SPACE = 1'b0;

   // Clock cycles per bit time; integer division, so the line rate rounds up slightly.
   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with registered read data.
// Latency: dout valid the cycle after rd_en is sampled high; count/flags update on the same edge.
// Backpressure: writes while full and reads while empty are ignored.
module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             do_wr, do_rd;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = dout_q;
   assign count = count_q;

   always_comb begin
      do_wr  = wr_en && !full;
      do_rd  = rd_en && !empty;
      wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
      rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
      dout_d = do_rd ? mem_q[rptr_q] : dout_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..SYMBOL_EDGE_TIME-1 and pulses tick on the last count.
// clr restarts the count so the next cycle is the first of a fresh bit time.
module uart_baud_counter #(
   parameter int SYMBOL_EDGE_TIME = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tick = (count_q == LAST);

   always_comb begin
      count_d = (clr || tick) ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the transmit FIFO and sends each byte as an 8N1 UART frame, LSB first (FIFO_UART_TX_PARITY_EN adds even parity).
// Latency: fifo_rd_en one cycle after fifo_empty falls in IDLE, start bit two cycles after fifo_rd_en.
// Backpressure: reads only from IDLE when the FIFO is non-empty; one byte in flight, no stall once a frame starts.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int WIDTH      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd_en,
   output logic             serial_out,
   output logic             busy
);

   localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

   uart_state_t          state_q, state_d;
   logic [WIDTH-1:0]     shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 serial_q, serial_d;
   logic                 rd_en_q, rd_en_d;
   logic                 busy_q, busy_d;
   logic                 bit_end;
   logic                 baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_baud_counter #(
      .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr),
      .tick (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE:  if (!fifo_empty) state_d = REQ;
         REQ:   state_d = LATCH;
         LATCH: begin
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d  = ^fifo_dout;
`endif
            state_d   = START;
         end
         START: if (bit_end) state_d = DATA;
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP:  if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      baud_clr = (state_d != state_q);
      rd_en_d  = (state_d == REQ);
      busy_d   = (state_d != IDLE);
      case (state_d)
         START:   serial_d = SPACE;
         DATA:    serial_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  serial_d = parity_d;
`endif
         default: serial_d = MARK;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         serial_q  <= MARK;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         serial_q  <= serial_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign serial_out = serial_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx fed by a real FIFO; a line-level UART decoder checks frames against a byte scoreboard.
module tb_fifo_uart_tx;

   localparam int SET = 10;
   localparam int W   = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = W + 3;
`else
   localparam int NB = W + 2;
`endif
   localparam int BUSY_CYC = NB * SET + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_rst;
   logic       wr_en;
   logic [7:0] din;
   logic       full;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rd_en;
   logic       serial_out;
   logic       busy;
   logic [5:0] fifo_count;

   int n_checks  = 0;
   int n_pass    = 0;
   int n_pushed  = 0;
   int rd_pulses = 0;
   int rd_viol   = 0;
   int last_gap  = -1;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   fifo #(.WIDTH(8), .DEPTH(32)) u_fifo (
      .clk   (clk),
      .rst   (fifo_rst),
      .wr_en (wr_en),
      .din   (din),
      .full  (full),
      .rd_en (fifo_rd_en),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   fifo_uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .serial_out (serial_out),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      wr_en = 1'b1;
      din   = b;
      exp_q.push_back(b);
      n_pushed++;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int i;
      i = 0;
      while (!(exp_q.size() == 0 && !busy && fifo_empty) && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, (exp_q.size() == 0 && !busy && fifo_empty), 1);
   endtask

   // Read-strobe watcher: sampled at the edge where the FIFO acts on it.
   initial begin : rd_watch
      logic prev_rd;
      prev_rd = 1'b0;
      forever begin
         @(posedge clk);
         if (fifo_rd_en === 1'b1) begin
            rd_pulses++;
            if (fifo_empty) rd_viol++;
            if (prev_rd) rd_viol++;
         end
         prev_rd = fifo_rd_en;
      end
   end

   // Line decoder: every bit window must hold one level for exactly SET samples.
   initial begin : line_monitor
      int         gap;
      logic [NB-1:0] lv;
      bit         ok, aborted;
      logic [7:0] exp;
      gap = -1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            gap = -1;
         end else if (serial_out === 1'b1) begin
            if (gap >= 0) gap++;
         end else begin
            last_gap = gap;
            ok = 1'b1;
            aborted = 1'b0;
            lv = '0;
            for (int b = 0; b < NB && !aborted; b++) begin
               for (int c = 0; c < SET && !aborted; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (rst !== 1'b0) aborted = 1'b1;
                  else if (c == 0) lv[b] = serial_out;
                  else if (serial_out !== lv[b]) ok = 1'b0;
               end
            end
            if (aborted) begin
               gap = -1;
            end else begin
               check("framing", (ok && lv[0] == 1'b0 && lv[NB-1] == 1'b1), 1);
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {24'd0, lv[8:1]}, 32'hFFFF_FFFF);
               end else begin
                  exp = exp_q.pop_front();
                  check("frame_data", lv[8:1], exp);
`ifdef FIFO_UART_TX_PARITY_EN
                  check("parity_bit", lv[9], ^exp);
`endif
               end
               gap = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int i, n, b, cnt_before, rd_base;
      rst      = 1'b1;
      fifo_rst = 1'b1;
      wr_en    = 1'b0;
      din      = 8'h00;
      #1;
      check("reset_serial_out", serial_out, 1);
      check("reset_busy", busy, 0);
      check("reset_rd_en", fifo_rd_en, 0);
      check("reset_fifo_empty", fifo_empty, 1);
      repeat (3) @(negedge clk);
      rst      = 1'b0;
      fifo_rst = 1'b0;

      // Single byte: latency, busy length, one read.
      rd_base = rd_pulses;
      push_byte(8'hA5);
      i = 0;
      while (!fifo_rd_en && i < 20) begin @(negedge clk); i++; end
      check("t2_rd_seen", fifo_rd_en, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (serial_out && n < 20);
      check("t2_start_latency", n, 2);
      b = 1 + n;
      i = 0;
      forever begin
         @(negedge clk);
         if (!busy || i > 500) break;
         b++;
         i++;
      end
      check("t2_busy_cycles", b, BUSY_CYC);
      wait_drain("t2_drain", 400);
      check("t2_read_pulses", rd_pulses - rd_base, 1);

      // Back-to-back bytes: gap and empty after second read.
      rd_base = rd_pulses;
      push_byte(8'h00);
      push_byte(8'hFF);
      i = 0;
      while (rd_pulses < rd_base + 2 && i < 400) begin @(negedge clk); i++; end
      check("t3_second_read", rd_pulses - rd_base, 2);
      check("t3_empty_after_read", fifo_empty, 1);
      wait_drain("t3_drain", 400);
      check("t3_mark_gap", last_gap, 3);

      // Idle with an empty FIFO.
      n = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (fifo_rd_en || !serial_out || busy) n++;
      end
      check("t4_idle_violations", n, 0);

      // Reset mid-DATA: line released at once, FIFO untouched, byte dropped.
      rd_base = rd_pulses;
      push_byte(8'hC3);
      push_byte(8'h5A);
      i = 0;
      while (rd_pulses < rd_base + 1 && i < 50) begin @(negedge clk); i++; end
      repeat (40) @(negedge clk);
      cnt_before = fifo_count;
      check("t1_count_before", cnt_before, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t1_serial_out_async", serial_out, 1);
      check("t1_busy_async", busy, 0);
      check("t1_rd_en_async", fifo_rd_en, 0);
      void'(exp_q.pop_front());
      repeat (3) @(negedge clk);
      check("t1_count_after", fifo_count, cnt_before);
      rst = 1'b0;
      wait_drain("t1_drain", 400);

      // Fill to full while the transmitter is held off, then release.
      rst = 1'b1;
      for (int k = 0; k < 32; k++) push_byte(8'(k));
      @(negedge clk);
      check("t5_full", full, 1);
      check("t5_count", fifo_count, 32);
      rst = 1'b0;
      i = 0;
      while (!fifo_rd_en && i < 20) begin @(negedge clk); i++; end
      check("t5_first_read", fifo_rd_en, 1);
      @(negedge clk);
      check("t5_full_deassert", full, 0);
      wait_drain("t5_drain", 5000);

`ifdef FIFO_UART_TX_PARITY_EN
      push_byte(8'h07);
      push_byte(8'h03);
      wait_drain("t6_drain", 600);
`endif

      // Random bytes with random spacing.
      for (int k = 0; k < 10; k++) begin
         push_byte(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 120)) @(negedge clk);
      end
      wait_drain("rand_drain", 2000);

      check("rd_strobe_violations", rd_viol, 0);
      check("total_reads", rd_pulses, n_pushed);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
